// File: rtl/n2t_pkg.sv
// Shared definitions for the n2t fetch/execute sequencer: FSM states and
// Hack instruction field positions.
package n2t_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_t;

    localparam int         C_MARK_MSB = 15;
    localparam int         C_MARK_LSB = 13;
    localparam int         JMP_MSB    = 2;
    localparam int         JMP_LSB    = 0;
    localparam logic [2:0] C_MARK     = 3'b111;
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/n2t_jump_eval.sv
// Combinational Hack jump decision from an instruction word and the ALU flags.
// A-instructions never jump.
module n2t_jump_eval
    import n2t_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] instr,
    input  logic             zr,
    input  logic             ng,
    output logic             take
);

    logic       is_c;
    logic [2:0] jmp;
    logic       unused_bits;

    always_comb begin
        is_c        = (instr[C_MARK_MSB:C_MARK_LSB] == C_MARK);
        jmp         = instr[JMP_MSB:JMP_LSB];
        take        = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
        unused_bits = ^instr;
    end

endmodule

// File: rtl/n2t_pc_sequencer.sv
// Fetch/execute controller driving the Hack PC reset/load/inc controls.
// Optional retired-instruction counter: define N2T_SEQ_RETIRE_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RST   | one-cycle pc_reset pulse after reset release
// ST_IDLE  | waiting for run
// ST_FETCH | rom_req high, waiting for rom_ready (timeout guarded)
// ST_EXEC  | one-cycle commit strobe with pc_load or pc_inc
// ST_HALT  | jump-to-self seen, sticky until reset
// ST_FAULT | fetch timeout, sticky until reset
module n2t_pc_sequencer
    import n2t_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             rom_ready,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] pc_cur,
    input  logic [WIDTH-1:0] a_reg,
    output logic             rom_req,
    output logic [WIDTH-1:0] instr,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_inc,
    output logic             exec_en,
    output logic             halted,
    output logic             fault
`ifdef N2T_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]      retired
`endif
);

    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic          halt_pend;
    logic          take;
    logic          halt_hit;

    // Decision is made on the word arriving from ROM so that the PC controls
    // are already registered when EXEC begins.
    n2t_jump_eval #(.WIDTH(WIDTH)) u_jump_eval (
        .instr (rom_data),
        .zr    (zr),
        .ng    (ng),
        .take  (take)
    );

    always_comb begin
        halt_hit = take && (rom_data[JMP_MSB:JMP_LSB] == JMP_ALWAYS) && (a_reg == pc_cur);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RST;
            wait_cnt  <= '0;
            halt_pend <= 1'b0;
            instr     <= '0;
            rom_req   <= 1'b0;
            pc_reset  <= 1'b0;
            pc_load   <= 1'b0;
            pc_inc    <= 1'b0;
            exec_en   <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            rom_req  <= 1'b0;
            pc_reset <= 1'b0;
            pc_load  <= 1'b0;
            pc_inc   <= 1'b0;
            exec_en  <= 1'b0;
            case (state)
                ST_RST: begin
                    // pc_reset doubles as the "pulse already issued" marker
                    if (!pc_reset) begin
                        pc_reset <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        rom_req  <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (rom_ready) begin
                        state     <= ST_EXEC;
                        instr     <= rom_data;
                        exec_en   <= 1'b1;
                        pc_load   <= take;
                        pc_inc    <= ~take;
                        halt_pend <= halt_hit;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TC_LAST)) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        rom_req  <= 1'b1;
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_EXEC: begin
                    if (halt_pend) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (run) begin
                        state    <= ST_FETCH;
                        rom_req  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_RST;
            endcase
        end
    end

`ifdef N2T_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if ((state == ST_EXEC) && (retired != 32'hFFFF_FFFF)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_n2t_pc_sequencer.sv
// Self-checking bench for n2t_pc_sequencer with a 4-cycle fetch timeout.
module tb_n2t_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        rom_ready = 1'b0;
    logic [15:0] rom_data = '0;
    logic        zr = 1'b0;
    logic        ng = 1'b0;
    logic [15:0] pc_cur = '0;
    logic [15:0] a_reg = '0;
    logic        rom_req, pc_reset, pc_load, pc_inc, exec_en, halted, fault;
    logic [15:0] instr;
`ifdef N2T_SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int errors = 0;
    int checks = 0;
    int exp_retired = 0;

    localparam logic [6:0] C_REQ   = 7'b1000000;
    localparam logic [6:0] C_RST   = 7'b0100000;
    localparam logic [6:0] C_LOAD  = 7'b0010000;
    localparam logic [6:0] C_INC   = 7'b0001000;
    localparam logic [6:0] C_EXEC  = 7'b0000100;
    localparam logic [6:0] C_HALT  = 7'b0000010;
    localparam logic [6:0] C_FAULT = 7'b0000001;

    wire [6:0] ctl = {rom_req, pc_reset, pc_load, pc_inc, exec_en, halted, fault};

    n2t_pc_sequencer #(.WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .rom_ready (rom_ready),
        .rom_data  (rom_data),
        .zr        (zr),
        .ng        (ng),
        .pc_cur    (pc_cur),
        .a_reg     (a_reg),
        .rom_req   (rom_req),
        .instr     (instr),
        .pc_reset  (pc_reset),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .exec_en   (exec_en),
        .halted    (halted),
        .fault     (fault)
`ifdef N2T_SEQ_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump semantics stated on the signed ALU result v (ng = v<0, zr = v==0).
    function automatic bit model_take(input logic [15:0] ins, input int v);
        logic [2:0] mark;
        logic [2:0] j;
        mark = ins[15:13];
        j    = ins[2:0];
        if (mark != 3'b111) return 1'b0;
        case (j)
            3'd0:    return 1'b0;
            3'd1:    return v > 0;
            3'd2:    return v == 0;
            3'd3:    return v >= 0;
            3'd4:    return v < 0;
            3'd5:    return v != 0;
            3'd6:    return v <= 0;
            default: return 1'b1;
        endcase
    endfunction

    // Reset, release, and leave the DUT in FETCH cycle 0 with run=1.
    task automatic reset_to_fetch();
        reset_n = 1'b0; run = 1'b0; rom_ready = 1'b0;
        exp_retired = 0;
        step();
        reset_n = 1'b1;
        step();
        step();
        run = 1'b1;
        step();
    endtask

    // Precondition: DUT in FETCH cycle 0.  Ready arrives after d idle cycles.
    task automatic do_instr(input string tag, input logic [15:0] ins, input int v,
                            input logic [15:0] a, input logic [15:0] pc, input int d);
        bit         tk;
        bit         hlt;
        logic [6:0] exp;
        tk  = model_take(ins, v);
        hlt = tk && (ins[2:0] == 3'b111) && (a == pc);
        rom_data = ins; zr = (v == 0); ng = (v < 0); a_reg = a; pc_cur = pc;
        rom_ready = 1'b0;
        for (int i = 0; i < d; i++) begin
            step();
            checks++;
            if (ctl !== C_REQ) begin
                errors++;
                $display("FAIL %s_wait: ctl=%b required=%b", tag, ctl, C_REQ);
            end
        end
        rom_ready = 1'b1;
        step();
        exp = C_EXEC | (tk ? C_LOAD : C_INC);
        exp_retired++;
        checks++;
        if (ctl !== exp) begin
            errors++;
            $display("FAIL %s_exec: instr=%h v=%0d ctl=%b required=%b", tag, ins, v, ctl, exp);
        end
        checks++;
        if (instr !== ins) begin
            errors++;
            $display("FAIL %s_instr: instr=%h required=%h", tag, instr, ins);
        end
        rom_ready = 1'b0;
        step();
        exp = hlt ? C_HALT : (run ? C_REQ : 7'b0);
        checks++;
        if (ctl !== exp) begin
            errors++;
            $display("FAIL %s_next: ctl=%b required=%b", tag, ctl, exp);
        end
    endtask

    task automatic test_reset();
        logic [6:0] seq [8];
        seq = '{C_RST, 7'b0, C_REQ, C_EXEC | C_INC, C_REQ, C_EXEC | C_INC, C_REQ, C_EXEC | C_INC};
        reset_n = 1'b0;
        exp_retired = 0;
        step();
        checks++;
        if ({ctl, instr} !== 23'b0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b instr=%h required all zero", ctl, instr);
        end
        reset_n = 1'b1; run = 1'b1; rom_ready = 1'b1; rom_data = 16'h0007;
        for (int i = 0; i < 8; i++) begin
            step();
            if ((seq[i] & C_EXEC) != 0) exp_retired++;
            checks++;
            if (ctl !== seq[i]) begin
                errors++;
                $display("FAIL startup_cycle%0d: ctl=%b required=%b", i, ctl, seq[i]);
            end
        end
        rom_ready = 1'b0;
        step();
        checks++;
        if (ctl !== C_REQ) begin
            errors++;
            $display("FAIL startup_refetch: ctl=%b required=%b", ctl, C_REQ);
        end
    endtask

    task automatic test_jump_directed();
        do_instr("jeq_taken",  16'hE302, 0,  16'h0040, 16'h0003, 0);
        do_instr("jeq_not",    16'hE302, 5,  16'h0040, 16'h0004, 1);
        do_instr("jlt_taken",  16'hE304, -3, 16'h0050, 16'h0005, 2);
        do_instr("jlt_not",    16'hE304, 9,  16'h0050, 16'h0006, 0);
        do_instr("a_instr",    16'h0007, int'($urandom_range(0, 2)) - 1, 16'h0007, 16'h0007, 3);
        do_instr("jmp_nohalt", 16'hEA87, 0,  16'h0011, 16'h0010, 0);
    endtask

    task automatic test_random();
        logic [15:0] ins, a, pc;
        int          v;
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ins[15:13] = 3'b111;
            case ($urandom_range(0, 2))
                0:       v = -int'($urandom_range(1, 100));
                1:       v = 0;
                default: v = int'($urandom_range(1, 100));
            endcase
            a  = 16'($urandom);
            pc = 16'($urandom);
            if (ins[15:13] == 3'b111 && ins[2:0] == 3'b111 && a == pc) pc = a + 16'd1;
            do_instr("random", ins, v, a, pc, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_run_drop();
        rom_ready = 1'b0;
        step();
        run = 1'b0;
        step();
        checks++;
        if (ctl !== C_REQ) begin
            errors++;
            $display("FAIL run_drop_fetch: ctl=%b required=%b", ctl, C_REQ);
        end
        do_instr("run_drop", 16'hE302, 0, 16'h0020, 16'h0021, 0);
        step();
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL run_drop_idle: ctl=%b required=%b", ctl, 7'b0);
        end
        run = 1'b1;
        step();
        checks++;
        if (ctl !== C_REQ) begin
            errors++;
            $display("FAIL run_resume: ctl=%b required=%b", ctl, C_REQ);
        end
    endtask

    task automatic test_async_reset();
        rom_ready = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ctl, instr} !== 23'b0) begin
            errors++;
            $display("FAIL async_reset: ctl=%b instr=%h required all zero", ctl, instr);
        end
        exp_retired = 0;
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (ctl !== C_RST) begin
            errors++;
            $display("FAIL async_reset_pulse: ctl=%b required=%b", ctl, C_RST);
        end
        step();
        step();
    endtask

    task automatic test_timeout();
        rom_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (ctl !== ((i < 4) ? C_REQ : C_FAULT)) begin
                errors++;
                $display("FAIL timeout_cycle%0d: ctl=%b required=%b", i, ctl,
                         (i < 4) ? C_REQ : C_FAULT);
            end
        end
        rom_ready = 1'b1;
        step();
        step();
        checks++;
        if (ctl !== C_FAULT) begin
            errors++;
            $display("FAIL fault_sticky: ctl=%b required=%b", ctl, C_FAULT);
        end
    endtask

    task automatic test_halt();
        do_instr("halt", 16'hEA87, 0, 16'h0010, 16'h0010, 1);
        rom_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ctl !== C_HALT) begin
                errors++;
                $display("FAIL halt_sticky%0d: ctl=%b required=%b", i, ctl, C_HALT);
            end
        end
`ifdef N2T_SEQ_RETIRE_CNT_EN
        checks++;
        if (retired !== 32'(exp_retired)) begin
            errors++;
            $display("FAIL retired: retired=%0d required=%0d", retired, exp_retired);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_jump_directed();
        test_random();
        test_run_drop();
        test_timeout();
        reset_to_fetch();
        do_instr("after_fault", 16'hE301, 4, 16'h0100, 16'h0000, 0);
        test_async_reset();
        run = 1'b1;
        step();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/n2t_pc_sequencer.md
Name: n2t_pc_sequencer

Overview:
Fetch/execute controller for the Hack CPU program counter.
- Sequences instruction fetch from ROM with a ready handshake.
- Evaluates the C-instruction jump condition against the ALU flags.
- Drives the PC's reset/load/inc controls.
- Issues a one-cycle commit strobe for A/D/M writes.
- Detects halt (unconditional jump-to-self) and fetch timeouts.
- Sits between the ROM interface, the ALU flag outputs and the n2t PC register.

Parameters:
- WIDTH, 16, address/instruction width.
- TIMEOUT_CYCLES, 255, maximum FETCH wait cycles before entering FAULT; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level enable; 1 allows execution to proceed.
- rom_ready  in  1  ROM data valid this cycle.
- rom_data  in  WIDTH  instruction word from ROM.
- zr  in  1  ALU zero flag.
- ng  in  1  ALU negative flag.
- pc_cur  in  WIDTH  current PC register output.
- a_reg  in  WIDTH  A register value (jump target).
- rom_req  out  1  fetch request to ROM.
- instr  out  WIDTH  latched current instruction.
- pc_reset  out  1  PC reset control.
- pc_load  out  1  PC load control (PC in = a_reg, wired externally).
- pc_inc  out  1  PC increment control.
- exec_en  out  1  one-cycle commit strobe for the executing instruction.
- halted  out  1  sticky halt flag.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=RST.
  - All outputs 0, instr=0.
  - Timeout counter 0.
- States: RST, IDLE, FETCH, EXEC, HALT, FAULT. All outputs are registered.
- RST:
  - pc_reset=1 for exactly one cycle after reset release.
  - Then IDLE.
- IDLE:
  - All controls 0.
  - run=1 -> FETCH next cycle.
- FETCH:
  - rom_req=1.
  - rom_ready=1 -> instr<=rom_data, go to EXEC.
  - Otherwise stay and increment the wait counter.
  - Counter reaches TIMEOUT_CYCLES (when TIMEOUT_CYCLES != 0) -> FAULT.
  - Counter clears on every entry to FETCH.
  - run falling during FETCH does not abort; the fetch completes.
- EXEC (exactly one cycle):
  - exec_en=1.
  - Jump taken, C-instr (instr[15:13]==3'b111):
    - take = (instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr).
    - A-instr: take=0.
  - take=1 -> pc_load=1, pc_inc=0.
  - take=0 -> pc_inc=1, pc_load=0.
  - pc_load and pc_inc are never both 1.
  - Halt condition: C-instr & instr[2:0]==3'b111 & a_reg==pc_cur.
    - pc_load=1 still asserted in this cycle.
    - Then HALT.
  - Otherwise next state is FETCH if run=1, else IDLE.
- HALT:
  - halted=1, all PC controls 0, rom_req=0.
  - Left only by reset.
- FAULT:
  - fault=1, all controls 0.
  - Left only by reset.
- Minimum instruction period is 2 cycles (FETCH with immediate ready, then EXEC).
- Wrap-around: PC overflow is the PC's concern; the sequencer applies no bound checks.
- Reset mid-operation: immediate return to RST; a partially fetched instr is discarded.

Optional Feature:
- Macro N2T_SEQ_RETIRE_CNT_EN.
- With it defined:
  - Adds output retired [31:0], counting EXEC cycles.
  - Reset to 0, saturates at 32'hFFFFFFFF.
- Without it: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package n2t_pkg holds:
  - State enum constants.
  - Instruction field positions: C-instr marker bits 15:13, jump bits 2:0.
  - Jump-code constant JMP_ALWAYS=3'b111.
- One natural sub-module: n2t_jump_eval, a combinational take-decision from instr, zr and ng. It is reusable by the CPU decoder.

Test Plan:
- Release reset with run=1 and rom_ready tied 1 -> pc_reset pulses 1 cycle; rom_req, then EXEC with pc_inc=1 every 2 cycles.
- instr=16'hE302 (JEQ), zr=1 -> pc_load=1, pc_inc=0 in EXEC; same instr with zr=0 -> pc_inc=1.
- instr=16'hE304 (JLT): ng=1 -> load; ng=0, zr=0 -> inc.
- A-instr 16'h0007 -> pc_inc=1 regardless of flags.
- instr=16'hEA87 (0;JMP), a_reg==pc_cur=16'h0010 -> pc_load=1, then halted=1 held, rom_req=0 thereafter.
- rom_ready held 0 with TIMEOUT_CYCLES=4 -> fault=1 after 4 wait cycles.
- Drop run mid-FETCH, then ready arrives -> EXEC completes, then IDLE.
- Assert reset_n=0 during FETCH -> all outputs 0 asynchronously.
